// File: rtl/pll_drp_ctrl_pkg.sv
// Clock-configuration constants shared by the PLL DRP sequencer: mode encodings,
// DRP entry layout and the per-mode register table.
package clk_cfg_pkg;

    localparam int NUM_MODES = 2;
    localparam int ENTRIES   = 4;
    localparam int MSEL_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    // One spare bit lets an out-of-range request be expressed and then rejected.
    localparam int MODE_W    = MSEL_W + 1;
    localparam int IDX_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [MODE_W-1:0] MODE_VGA_640  = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_SVGA_800 = MODE_W'(1);

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT_RST,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RELEASE,
        S_WAIT_LOCK
    } ctrl_state_e;

    // CLKOUT1 reg1/reg2, CLKFBOUT reg1/reg2; mask bits set are preserved from the read.
    localparam drp_entry_t DRP_TABLE [NUM_MODES][ENTRIES] = '{
        '{ '{7'h0A, 16'h1000, 16'h0208}, '{7'h0B, 16'hFC00, 16'h0000},
           '{7'h14, 16'h1000, 16'h0410}, '{7'h15, 16'hFC00, 16'h0000} },
        '{ '{7'h0A, 16'h1000, 16'h0186}, '{7'h0B, 16'hFC00, 16'h0080},
           '{7'h14, 16'h1000, 16'h0514}, '{7'h15, 16'hFC00, 16'h0000} }
    };

    function automatic drp_entry_t table_entry(input logic [MSEL_W-1:0] mode,
                                               input logic [IDX_W-1:0]  idx);
        return DRP_TABLE[mode][idx];
    endfunction

endpackage

// File: rtl/pll_drp_ctrl_if.sv
// DRP bus between the reconfiguration sequencer (master) and the PLL (slave).
interface pll_drp_ctrl_if;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;

    modport master (output den, dwe, daddr, di, input dout, drdy);
    modport slave  (input den, dwe, daddr, di, output dout, drdy);
endinterface

// File: rtl/pll_drp_ctrl_lock_sync.sv
// Synchronizes the PLL LOCKED input and qualifies it with a run of consecutive
// locked cycles; lock_ok_o drops as soon as the synchronized lock does.
module lock_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic lock_ok_o
);
    localparam int CNT_W = $clog2(LOCK_STABLE + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lock_s;
    logic                   flag_q;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign lock_ok_o = flag_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!lock_s) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(LOCK_STABLE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            cnt_q  <= cnt_d;
            flag_q <= lock_s && (cnt_q == CNT_W'(LOCK_STABLE));
        end
    end
endmodule

// File: rtl/pll_drp_ctrl.sv
// PLL run-time reconfiguration sequencer: holds the PLL in reset, read-modify-writes
// the mode's DRP table, releases reset and waits for a stable lock.
// IDLE | wait for req    ASSERT_RST | PLL reset on    RD_ISSUE/RD_WAIT | DRP read
// WR_ISSUE/WR_WAIT | DRP merged write    RELEASE | PLL reset off    WAIT_LOCK | stable lock
module pll_drp_ctrl
    import clk_cfg_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_STABLE  = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 8192
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [MODE_W-1:0] mode_o,
    output logic              locked_o,
    pll_drp_ctrl_if.master    drp,
    output logic              pll_rst_o,
    input  logic              pll_locked_async_i
);
    localparam int TMO_W = $clog2((LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT);

    ctrl_state_e       state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d, mode_app_q, mode_app_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              drp_fail_q, drp_fail_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, pll_rst_q, pll_rst_d;
    logic              den_q, den_d, dwe_q, dwe_d;
    logic [6:0]        daddr_q, daddr_d;
    logic [15:0]       di_q, di_d;
    logic              lock_ok;
    drp_entry_t        entry_cur, entry_nxt;

    lock_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .async_i  (pll_locked_async_i),
        .lock_ok_o(lock_ok)
    );

    assign entry_cur = table_entry(mode_q[MSEL_W-1:0], idx_q);
    assign entry_nxt = table_entry(mode_q[MSEL_W-1:0], idx_q + 1'b1);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        mode_app_d = mode_app_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        drp_fail_d = drp_fail_q;
        daddr_d    = daddr_q;
        di_d       = di_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        den_d      = 1'b0;
        dwe_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (mode_i < MODE_W'(NUM_MODES)) begin
                        mode_d     = mode_i;
                        idx_d      = '0;
                        drp_fail_d = 1'b0;
                        state_d    = S_ASSERT_RST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ASSERT_RST: begin
                den_d   = 1'b1;
                daddr_d = entry_cur.addr;
                state_d = S_RD_ISSUE;
            end
            S_RD_ISSUE: begin
                tmo_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp.drdy) begin
                    di_d    = (drp.dout & entry_cur.mask) | entry_cur.data;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = S_WR_ISSUE;
                end else if (tmo_q == TMO_W'(DRDY_TIMEOUT - 1)) begin
                    drp_fail_d = 1'b1;
                    state_d    = S_RELEASE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp.drdy) begin
                    if (idx_q == IDX_W'(ENTRIES - 1)) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        den_d   = 1'b1;
                        daddr_d = entry_nxt.addr;
                        state_d = S_RD_ISSUE;
                    end
                end else if (tmo_q == TMO_W'(DRDY_TIMEOUT - 1)) begin
                    drp_fail_d = 1'b1;
                    state_d    = S_RELEASE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RELEASE: begin
                tmo_d   = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = S_IDLE;
                    if (drp_fail_q) begin
                        err_d = 1'b1;
                    end else begin
                        done_d     = 1'b1;
                        mode_app_d = mode_q;
                    end
                end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so the PLL reset never glitches.
        pll_rst_d = state_d inside {S_ASSERT_RST, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_WAIT};
        busy_d    = (state_d != S_IDLE) || (state_q != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            mode_app_q <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            drp_fail_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pll_rst_q  <= 1'b0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            mode_app_q <= mode_app_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            drp_fail_q <= drp_fail_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pll_rst_q  <= pll_rst_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign mode_o    = mode_app_q;
    assign pll_rst_o = pll_rst_q;
    assign locked_o  = lock_ok & ~busy_q;
    assign drp.den   = den_q;
    assign drp.dwe   = dwe_q;
    assign drp.daddr = daddr_q;
    assign drp.di    = di_q;
endmodule
